axis_position_register: RTL and testbench

//  Parametrised single-axis position register for moving blocks. Steps the position by a programmable

---
 rtl/axis_position_register.sv | 112 +++++++++++
 tb/tb_axis_position_register.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/axis_position_register.sv
// axis_position_register: single-axis position stepper with bounce/wrap/stop at [POS_MIN, POS_MAX].
// Optional macro AXIS_POS_BOUNCE_CNT_EN adds a saturating bounce_cnt output.
module axis_position_register #(
    parameter int WIDTH    = 8,
    parameter int POS_MIN  = 0,
    parameter int POS_MAX  = 144,
    parameter int POS_INIT = 0,
    parameter int DIR_INIT = 1,
    parameter int STEP_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sync,
    input  logic              enable,
    input  logic              load,
    input  logic              load_dir,
    input  logic [WIDTH-1:0]  load_pos,
    input  logic [1:0]        mode,
    input  logic [STEP_W-1:0] step,
    output logic [WIDTH-1:0]  pos,
    output logic              dir,
    output logic              edge_hit,
`ifdef AXIS_POS_BOUNCE_CNT_EN
    output logic [7:0]        bounce_cnt,
`endif
    output logic              stopped
);
    localparam logic [WIDTH:0]   L_MIN  = (WIDTH+1)'(POS_MIN);
    localparam logic [WIDTH:0]   L_MAX  = (WIDTH+1)'(POS_MAX);
    localparam logic [WIDTH:0]   L_MAX1 = (WIDTH+1)'(POS_MAX + 1);
    localparam logic [WIDTH:0]   L_SPAN = (WIDTH+1)'(POS_MAX - POS_MIN);
    localparam logic [WIDTH-1:0] N_MIN  = WIDTH'(POS_MIN);
    localparam logic [WIDTH-1:0] N_MAX  = WIDTH'(POS_MAX);

    logic [WIDTH-1:0] r_pos;
    logic             r_dir, r_edge, r_stopped, r_sync_q;
    logic [WIDTH:0]   w_pos_x, w_step_x, w_s, w_up, w_lo, w_bound, w_step_val, w_wrap_val, w_nxt_pos;
    logic             w_tick, w_hit, w_cross, w_nxt_dir, w_nxt_edge, w_nxt_stop;

    assign w_tick   = sync & ~r_sync_q & enable & ~r_stopped;
    assign w_pos_x  = {1'b0, r_pos};
    assign w_step_x = {{(WIDTH+1-STEP_W){1'b0}}, step};
    assign w_s      = (w_step_x > L_SPAN) ? L_SPAN : w_step_x;
    assign w_up     = w_pos_x + w_s;
    // Downward tests compare pos against POS_MIN+s so nothing ever goes negative.
    assign w_lo       = L_MIN + w_s;
    assign w_hit      = r_dir ? (w_up >= L_MAX) : (w_pos_x <= w_lo);
    assign w_cross    = r_dir ? (w_up > L_MAX) : (w_pos_x < w_lo);
    assign w_bound    = r_dir ? L_MAX : L_MIN;
    assign w_step_val = r_dir ? w_up : w_pos_x - w_s;
    assign w_wrap_val = r_dir ? L_MIN + w_up - L_MAX1 : L_MAX1 + w_pos_x - L_MIN - w_s;

    always_comb begin
        w_nxt_pos  = w_pos_x;
        w_nxt_dir  = r_dir;
        w_nxt_edge = 1'b0;
        w_nxt_stop = r_stopped;
        if (w_tick && w_s != '0) begin
            if (mode == 2'b01) begin
                w_nxt_edge = w_cross;
                w_nxt_pos  = w_cross ? w_wrap_val : w_step_val;
            end else if (mode == 2'b10) begin
                w_nxt_edge = w_hit;
                w_nxt_stop = w_hit;
                w_nxt_pos  = w_hit ? w_bound : w_step_val;
            end else begin
                w_nxt_edge = w_hit;
                w_nxt_pos  = w_hit ? w_bound : w_step_val;
                w_nxt_dir  = r_dir ^ w_hit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pos     <= WIDTH'(POS_INIT);
            r_dir     <= 1'(DIR_INIT);
            r_edge    <= 1'b0;
            r_stopped <= 1'b0;
            r_sync_q  <= 1'b0;
        end else begin
            r_sync_q <= sync;
            if (load) begin
                r_pos     <= (load_pos < N_MIN) ? N_MIN : (load_pos > N_MAX) ? N_MAX : load_pos;
                r_dir     <= load_dir;
                r_edge    <= 1'b0;
                r_stopped <= 1'b0;
            end else begin
                r_pos     <= w_nxt_pos[WIDTH-1:0];
                r_dir     <= w_nxt_dir;
                r_edge    <= w_nxt_edge;
                r_stopped <= w_nxt_stop;
            end
        end
    end

`ifdef AXIS_POS_BOUNCE_CNT_EN
    logic [7:0] r_bounce_cnt;
    always_ff @(posedge clk) begin
        if (reset || load)
            r_bounce_cnt <= '0;
        else if (w_nxt_edge && r_bounce_cnt != 8'hff)
            r_bounce_cnt <= r_bounce_cnt + 8'd1;
    end
    assign bounce_cnt = r_bounce_cnt;
`endif

    assign pos      = r_pos;
    assign dir      = r_dir;
    assign edge_hit = r_edge;
    assign stopped  = r_stopped;
endmodule

// File: tb/tb_axis_position_register.sv
// tb_axis_position_register: scoreboard bench; stimulus queues expected state, negedge monitor compares.
module tb_axis_position_register;
    logic       clk = 1'b0, reset = 1'b1, sync = 1'b0, enable = 1'b1, load = 1'b0, load_dir = 1'b0;
    logic [7:0] load_pos = '0;
    logic [1:0] mode = 2'b00;
    logic [3:0] step = 4'd1;
    logic [7:0] pos;
    logic       dir, edge_hit, stopped;
`ifdef AXIS_POS_BOUNCE_CNT_EN
    logic [7:0] bounce_cnt;
`endif

    typedef struct {
        string nm;
        int    due;
        int    p;
        bit    d;
        bit    eh;
        bit    s;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0, n_chk = 0, n_pass = 0;

    axis_position_register dut (
        .clk(clk), .reset(reset), .sync(sync), .enable(enable), .load(load),
        .load_dir(load_dir), .load_pos(load_pos), .mode(mode), .step(step),
        .pos(pos), .dir(dir), .edge_hit(edge_hit),
`ifdef AXIS_POS_BOUNCE_CNT_EN
        .bounce_cnt(bounce_cnt),
`endif
        .stopped(stopped)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() != 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            n_chk++;
            if (e.due == cyc && int'(pos) == e.p && dir == e.d && edge_hit == e.eh && stopped == e.s)
                n_pass++;
            else
                $display("FAIL %s: got pos=%0d dir=%0b edge_hit=%0b stopped=%0b, want pos=%0d dir=%0b edge_hit=%0b stopped=%0b",
                         e.nm, pos, dir, edge_hit, stopped, e.p, e.d, e.eh, e.s);
        end
    end

    task automatic chk(input string nm, input int p, input bit d, input bit eh, input bit s);
        q.push_back('{nm, cyc + 1, p, d, eh, s});
    endtask

    task automatic cyc1();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input string nm, input int lp, input bit ld, input int p);
        chk(nm, p, ld, 1'b0, 1'b0);
        load = 1'b1; load_pos = 8'(lp); load_dir = ld;
        cyc1();
        load = 1'b0;
    endtask

    task automatic tick(input string nm, input int p, input bit d, input bit eh, input bit s);
        chk(nm, p, d, eh, s);
        sync = 1'b1;
        cyc1();
        sync = 1'b0;
        chk({nm, "_after"}, p, d, 1'b0, s);
        cyc1();
    endtask

    initial begin
        #1;
        repeat (2) begin
            chk("reset", 0, 1, 0, 0);
            sync = ~sync;
            cyc1();
        end
        reset = 1'b0; sync = 1'b0;
        chk("post_reset", 0, 1, 0, 0);
        cyc1();

        mode = 2'b00; step = 4'd1;
        do_load("ld143", 143, 1, 143);
        tick("bnc_max", 144, 0, 1, 0);
        tick("bnc_143", 143, 0, 0, 0);
        tick("bnc_142", 142, 0, 0, 0);

        step = 4'd5;
        do_load("ld2", 2, 0, 2);
        tick("bnc_min", 0, 1, 1, 0);
        tick("bnc_5", 5, 1, 0, 0);

        mode = 2'b11;
        do_load("ld5", 5, 0, 5);
        tick("bnc_exact_min", 0, 1, 1, 0);

        mode = 2'b01; step = 4'd10;
        do_load("ld140", 140, 1, 140);
        tick("wrap_up", 5, 1, 1, 0);
        do_load("ld3", 3, 0, 3);
        tick("wrap_dn", 138, 0, 1, 0);
        do_load("ld134", 134, 1, 134);
        tick("wrap_exact_max", 144, 1, 0, 0);

        mode = 2'b10; step = 4'd4;
        do_load("ld142", 142, 1, 142);
        tick("stop_hit", 144, 1, 1, 1);
        repeat (3) tick("stop_hold", 144, 1, 0, 1);
        mode = 2'b00;
        tick("stop_mode_chg", 144, 1, 0, 1);
        do_load("ld200_clamp", 200, 1, 144);

        step = 4'd0;
        tick("step0_at_max", 144, 1, 0, 0);

        step = 4'd3;
        do_load("ld10", 10, 1, 10);
        chk("held_first", 13, 1, 0, 0);
        sync = 1'b1;
        cyc1();
        repeat (9) begin
            chk("held", 13, 1, 0, 0);
            cyc1();
        end
        sync = 1'b0;
        cyc1();

        enable = 1'b0;
        tick("enable_low", 13, 1, 0, 0);
        enable = 1'b1;
        tick("enable_high", 16, 1, 0, 0);

        chk("load_tick", 50, 0, 0, 0);
        sync = 1'b1; load = 1'b1; load_pos = 8'd50; load_dir = 1'b0;
        cyc1();
        load = 1'b0; sync = 1'b0;
        chk("load_tick_after", 50, 0, 0, 0);
        cyc1();

`ifdef AXIS_POS_BOUNCE_CNT_EN
        step = 4'd15; mode = 2'b00;
        do_load("ld0_cnt", 0, 1, 0);
        n_chk++;
        if (bounce_cnt == 8'd0) n_pass++;
        else $display("FAIL bounce_cnt_clear: got %0d want 0", bounce_cnt);
        repeat (3000) begin
            sync = 1'b1;
            cyc1();
            sync = 1'b0;
            cyc1();
        end
        n_chk++;
        if (bounce_cnt == 8'd255) n_pass++;
        else $display("FAIL bounce_cnt_sat: got %0d want 255", bounce_cnt);
`endif

        for (int i = 0; i < 20 && q.size() != 0; i++) cyc1();
        if (q.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending entries want 0", q.size());
            n_chk += q.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
